// File: rtl/fxp_sqrt_sched_pkg.sv
// Shared types and helpers for the round-robin sqrt scheduler.
// Widths are sized for the largest supported configuration (16 requesters,
// 16-deep result queues) so one tag/credit format serves every instance.
package fxp_sqrt_sched_pkg;

  localparam int NREQ_MAX = 16;
  localparam int OUTQ_MAX = 16;
  localparam int IDW      = $clog2(NREQ_MAX);
  localparam int CW       = $clog2(OUTQ_MAX + 1);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  // One-hot grant: first eligible requester at or after ptr, wrapping at n.
  function automatic logic [NREQ_MAX-1:0] rr_pick(input logic [NREQ_MAX-1:0] elig,
                                                  input logic [IDW-1:0]      ptr,
                                                  input int                  n);
    logic [NREQ_MAX-1:0] gnt;
    int                  idx;
    gnt = '0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && gnt == '0 && elig[idx[IDW-1:0]]) gnt[idx[IDW-1:0]] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fxp_sqrt_resq.sv
// Per-requester result FIFO with first-word-through head.
//   i_push/i_data : write port (never pushed while full; the credit scheme
//                   upstream guarantees a free slot)
//   i_pop         : consume head; ignored while empty
//   o_data        : head entry, 0 while empty
//   o_empty       : no entry stored
module fxp_sqrt_resq #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CNTW-1:0] r_cnt;
  logic            w_pop;

  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : r_mem[r_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                                  !(i_push && r_cnt == CNTW'(DEPTH)));

endmodule

// File: rtl/pipe_FixedPointSqrt.sv
// Pipelined signed fixed-point square root core.
//   i_in  : signed WII.WIF operand
//   o_out : WOI.WOF root, LAT clock edges after i_in is presented
//   o_ovf : set for negative operands (root forced to 0) or when the root
//           does not fit the output format (root saturated)
// ROUND != 0 rounds to nearest, otherwise truncates. No stall input.
module pipe_FixedPointSqrt #(
  parameter int WII   = 9,
  parameter int WIF   = 10,
  parameter int WOI   = 9,
  parameter int WOF   = 10,
  parameter int ROUND = 1,
  parameter int LAT   = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WII+WIF-1:0]   i_in,
  output logic [WOI+WOF-1:0]   o_out,
  output logic                 o_ovf
);

  localparam int IW = WII + WIF;
  localparam int OW = WOI + WOF;
  // Radicand is scaled so its integer sqrt lands directly in WOF fraction bits.
  localparam int SH     = 2 * WOF - WIF;
  localparam int RW_RAW = IW - 1 + SH;
  localparam int RW     = RW_RAW + (RW_RAW % 2);
  localparam int HW     = RW / 2;
  localparam longint MAXPOS = (longint'(1) << (OW - 1)) - 1;

  logic [RW-1:0] w_rad, w_rem, w_res, w_one;
  logic [RW:0]   w_root;
  logic [OW-1:0] w_val;
  logic          w_ovf;

  always_comb begin
    w_rad = RW'(i_in[IW-2:0]) << SH;
    w_rem = w_rad;
    w_res = '0;
    w_one = RW'(1) << (RW - 2);
    for (int k = 0; k < HW; k++) begin
      if (w_rem >= w_res + w_one) begin
        w_rem = w_rem - (w_res + w_one);
        w_res = (w_res >> 1) + w_one;
      end else begin
        w_res = w_res >> 1;
      end
      w_one = w_one >> 2;
    end
    // w_rem = rad - res^2; res+0.5 squared never equals an integer, so no ties.
    w_root = (ROUND != 0 && w_rem > w_res) ? {1'b0, w_res} + 1'b1 : {1'b0, w_res};
    if (i_in[IW-1]) begin
      w_val = '0;
      w_ovf = 1'b1;
    end else if (longint'(w_root) > MAXPOS) begin
      w_val = OW'(MAXPOS);
      w_ovf = 1'b1;
    end else begin
      w_val = w_root[OW-1:0];
      w_ovf = 1'b0;
    end
  end

  logic [OW:0] r_pipe [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) r_pipe[k] <= '0;
    end else begin
      r_pipe[0] <= {w_ovf, w_val};
      for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign {o_ovf, o_out} = r_pipe[LAT-1];

endmodule

// File: rtl/fxp_sqrt_rr_scheduler.sv
// Shares one pipe_FixedPointSqrt core between NREQ requesters.
//   req_valid/req_ready/req_data : operand ports, round-robin arbitrated,
//                                  at most one grant per cycle
//   res_valid/res_ready/res_data/res_ovf : per-requester result queues
//   busy : registered; something was in flight or queued last cycle
// A requester is only granted while it holds a credit, i.e. a result slot
// that no in-flight or queued result has claimed, so the core never stalls.
module fxp_sqrt_rr_scheduler
  import fxp_sqrt_sched_pkg::*;
#(
  parameter int WII   = 9,
  parameter int WIF   = 10,
  parameter int WOI   = 9,
  parameter int WOF   = 10,
  parameter int ROUND = 1,
  parameter int NREQ  = 4,
  parameter int LAT   = 21,
  parameter int OUTQ  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*(WII+WIF)-1:0]  req_data,
  output logic [NREQ-1:0]            res_valid,
  input  logic [NREQ-1:0]            res_ready,
  output logic [NREQ*(WOI+WOF)-1:0]  res_data,
  output logic [NREQ-1:0]            res_ovf,
  output logic                       busy
);

  localparam int IW = WII + WIF;
  localparam int OW = WOI + WOF;
  localparam int FW = OW + 1;

  logic [CW-1:0]       r_credit [NREQ];
  logic [IDW-1:0]      r_ptr;
  logic [IW-1:0]       r_in;
  tag_t                r_tag [LAT+1];
  tag_t                r_ret_tag;
  logic [FW-1:0]       r_ret_data;
  logic                r_busy;

  logic [NREQ-1:0]     w_elig, w_grant, w_pop, w_empty, w_push;
  logic [NREQ_MAX-1:0] w_elig_ext, w_pick;
  logic [IDW-1:0]      w_gid;
  logic                w_gvld;
  logic                w_tag_any;
  logic [OW-1:0]       w_core_out;
  logic                w_core_ovf;
  logic [FW-1:0]       w_q [NREQ];
  logic                w_unused_pick;

  // Arbitration
  always_comb begin
    for (int i = 0; i < NREQ; i++) w_elig[i] = req_valid[i] && (r_credit[i] != '0);
    w_elig_ext             = '0;
    w_elig_ext[NREQ-1:0]   = w_elig;
    w_pick                 = rr_pick(w_elig_ext, r_ptr, NREQ);
    w_grant                = rst ? '0 : w_pick[NREQ-1:0];
    w_gid                  = '0;
    for (int i = 0; i < NREQ; i++) if (w_grant[i]) w_gid = IDW'(i);
    w_gvld                 = |w_grant;
  end

  assign w_unused_pick = ^w_pick;
  assign req_ready     = w_grant;
  assign w_pop         = ~w_empty & res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      for (int i = 0; i < NREQ; i++) r_credit[i] <= CW'(OUTQ);
    end else begin
      if (w_gvld) r_ptr <= (w_gid == IDW'(NREQ - 1)) ? '0 : w_gid + 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        case ({w_grant[i], w_pop[i]})
          2'b10:   r_credit[i] <= r_credit[i] - 1'b1;
          2'b01:   r_credit[i] <= r_credit[i] + 1'b1;
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end
  end

  // Issue register and tag pipe; tag stage LAT lines up with the core output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in <= '0;
      for (int k = 0; k <= LAT; k++) r_tag[k] <= '0;
    end else begin
      r_in     <= w_gvld ? req_data[w_gid*IW +: IW] : '0;
      r_tag[0] <= '{vld: w_gvld, id: w_gid};
      for (int k = 1; k <= LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  pipe_FixedPointSqrt #(
    .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF), .ROUND(ROUND), .LAT(LAT)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .i_in  (r_in),
    .o_out (w_core_out),
    .o_ovf (w_core_ovf)
  );

  // Retire stage: one register between core output and the FIFO demux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ret_tag  <= '0;
      r_ret_data <= '0;
    end else begin
      r_ret_tag  <= r_tag[LAT];
      r_ret_data <= {w_core_ovf, w_core_out};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_q
      assign w_push[gi] = r_ret_tag.vld && (r_ret_tag.id == IDW'(gi));
      fxp_sqrt_resq #(.DEPTH(OUTQ), .W(FW)) u_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[gi]),
        .i_data  (r_ret_data),
        .i_pop   (res_ready[gi]),
        .o_data  (w_q[gi]),
        .o_empty (w_empty[gi])
      );
      assign res_data[gi*OW +: OW] = w_q[gi][OW-1:0];
      assign res_ovf[gi]           = w_q[gi][OW];
    end
  endgenerate

  assign res_valid = ~w_empty;

  always_comb begin
    w_tag_any = r_ret_tag.vld;
    for (int k = 0; k <= LAT; k++) w_tag_any = w_tag_any | r_tag[k].vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= 1'b0;
    else     r_busy <= w_tag_any | ~&w_empty;
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_fxp_sqrt_rr_scheduler.sv
module tb_fxp_sqrt_rr_scheduler;

  localparam int N  = 4;
  localparam int Q  = 4;
  localparam int L  = 21;
  localparam int IW = 19;
  localparam int OW = 19;
  localparam int N1 = 2;
  localparam int Q1 = 1;
  localparam int L1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_valid, req_ready, res_valid, res_ready, res_ovf;
  logic [N*IW-1:0]   req_data;
  logic [N*OW-1:0]   res_data;
  logic              busy;

  logic              rst1;
  logic [N1-1:0]     req1_valid, req1_ready, res1_valid, res1_ready, res1_ovf;
  logic [N1*IW-1:0]  req1_data;
  logic [N1*OW-1:0]  res1_data;
  logic              busy1;

  fxp_sqrt_rr_scheduler #(.NREQ(N), .LAT(L), .OUTQ(Q)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ovf(res_ovf), .busy(busy));

  fxp_sqrt_rr_scheduler #(.NREQ(N1), .LAT(L1), .OUTQ(Q1)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(req1_valid), .req_ready(req1_ready),
    .req_data(req1_data), .res_valid(res1_valid), .res_ready(res1_ready),
    .res_data(res1_data), .res_ovf(res1_ovf), .busy(busy1));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference sqrt: value = in/2^10, root scaled by 2^10, nearest rounding.
  function automatic void model_sqrt(input logic [18:0] x, output logic [18:0] y, output logic ov);
    longint v, lo, hi, mid, s;
    if (x[18]) begin
      y = '0; ov = 1'b1;
      return;
    end
    v  = longint'(x) * 1024;
    lo = 0; hi = 1 << 20;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= v) lo = mid; else hi = mid;
    end
    s = lo;
    if (4 * v > (2 * s + 1) * (2 * s + 1)) s = s + 1;
    if (s > 262143) begin y = 19'h3FFFF; ov = 1'b1; end
    else begin y = 19'(s); ov = 1'b0; end
  endfunction

  function automatic logic [18:0] rnd_data();
    case ($urandom_range(0, 7))
      0: return 19'h00000;
      1: return 19'h7FFFF;
      2: return 19'h40000;
      3: return 19'h3FFFF;
      default: return 19'($urandom);
    endcase
  endfunction

  // Model: every issued op lives in mq (issue order) until its result is popped.
  typedef struct { int id; logic [18:0] d; logic o; int vis; } ent_t;
  ent_t mq[$];
  int   m_ptr, m_cyc, m_prev_live;
  int   g_cnt [N];

  function automatic int head_of(input int i);
    for (int k = 0; k < mq.size(); k++) if (mq[k].id == i) return k;
    return -1;
  endfunction

  function automatic int count_of(input int i);
    int c = 0;
    for (int k = 0; k < mq.size(); k++) if (mq[k].id == i) c++;
    return c;
  endfunction

  task automatic step();
    int            g, h;
    logic [N-1:0]  exp_rdy;
    logic          ev, del;
    int            hd [N];
    logic [18:0]   y;
    logic          ov;
    @(negedge clk);
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      mq.delete();
      m_ptr = 0;
      m_prev_live = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i] && count_of(i) < Q) g = i;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, m_prev_live != 0);
      for (int i = 0; i < N; i++) begin
        h     = head_of(i);
        ev    = (h >= 0) && (mq[h].vis <= m_cyc);
        hd[i] = -1;
        chk($sformatf("res_valid[%0d]", i), res_valid[i], ev);
        if (ev) begin
          chk($sformatf("res_data[%0d]", i), res_data[i*OW +: OW], mq[h].d);
          chk($sformatf("res_ovf[%0d]", i), res_ovf[i], mq[h].o);
          if (res_ready[i]) hd[i] = h;
        end
        if (req_ready[i]) g_cnt[i]++;
      end
      m_prev_live = mq.size();
      for (int j = mq.size() - 1; j >= 0; j--) begin
        del = 1'b0;
        for (int i = 0; i < N; i++) if (hd[i] == j) del = 1'b1;
        if (del) mq.delete(j);
      end
      if (g >= 0) begin
        model_sqrt(req_data[g*IW +: IW], y, ov);
        mq.push_back('{id: g, d: y, o: ov, vis: m_cyc + L + 3});
        m_ptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    m_cyc++;
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) req_data[i*IW +: IW] = rnd_data();
  endtask

  typedef struct { logic [18:0] in; logic [18:0] out; logic ovf; } vec_t;
  vec_t tbl [10];

  int   lat;
  int   last, ngr;
  logic [19:0] q1 [$];
  logic [18:0] y1;
  logic        o1;

  initial begin
    tbl[0] = '{19'h00000, 19'h00000, 1'b0};
    tbl[1] = '{19'h01000, 19'h00800, 1'b0};
    tbl[2] = '{19'h7FFFF, 19'h00000, 1'b1};
    tbl[3] = '{19'h40000, 19'h00000, 1'b1};
    tbl[4] = '{19'h00400, 19'h00400, 1'b0};
    tbl[5] = '{19'h3FFFF, 19'h04000, 1'b0};
    tbl[6] = '{19'h00001, 19'h00020, 1'b0};
    tbl[7] = '{19'h00900, 19'h00600, 1'b0};
    tbl[8] = '{19'h00200, 19'h002D4, 1'b0};
    tbl[9] = '{19'h0000E, 19'h00078, 1'b0};

    rst = 1'b1; rst1 = 1'b1;
    req_valid = '0; res_ready = '0; req_data = '0;
    req1_valid = '0; res1_ready = '0; req1_data = '0;
    m_ptr = 0; m_cyc = 0; m_prev_live = 0;
    for (int i = 0; i < N; i++) g_cnt[i] = 0;

    step(); step();
    rst = 1'b0;
    step();

    // Single op on requester 0: latency and value.
    res_ready = '1;
    req_valid = 4'b0001;
    req_data[0 +: IW] = 19'h01000;
    step();
    req_valid = '0;
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      step();
      if (res_valid[0]) begin
        lat = k;
        chk("t1_data", res_data[0 +: OW], 19'h00800);
        chk("t1_ovf", res_ovf[0], 0);
      end
    end
    chk("t1_latency", lat, L + 2);

    // Table vectors, rotated across requesters.
    for (int v = 0; v < 10; v++) begin
      int r, got;
      r = v % N;
      req_valid = '0;
      req_valid[r] = 1'b1;
      req_data[r*IW +: IW] = tbl[v].in;
      step();
      req_valid = '0;
      got = 0;
      for (int k = 0; k < 60 && got == 0; k++) begin
        step();
        if (res_valid[r]) begin
          got = 1;
          chk($sformatf("tbl%0d_data", v), res_data[r*OW +: OW], tbl[v].out);
          chk($sformatf("tbl%0d_ovf", v), res_ovf[r], tbl[v].ovf);
        end
      end
      chk($sformatf("tbl%0d_seen", v), got, 1);
    end

    // All requesters streaming, all results consumed.
    req_valid = '1; res_ready = '1;
    for (int k = 0; k < 200; k++) begin rand_data(); step(); end

    // Drain, then block requester 2's results.
    req_valid = '0;
    for (int k = 0; k < L + 6; k++) step();
    for (int i = 0; i < N; i++) g_cnt[i] = 0;
    req_valid = '1; res_ready = 4'b1011;
    for (int k = 0; k < 80; k++) begin rand_data(); step(); end
    chk("t3_grants_blocked", g_cnt[2], Q);
    res_ready = '1;
    for (int k = 0; k < 80; k++) begin rand_data(); step(); end
    chk("t3_grants_resumed", g_cnt[2] > Q, 1);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      req_valid = 4'($urandom);
      res_ready = 4'($urandom);
      rand_data();
      step();
    end

    // Reset with work in flight and queued.
    req_valid = '1; res_ready = 4'b0011;
    for (int k = 0; k < 30; k++) begin rand_data(); step(); end
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0; res_ready = '1;
    for (int k = 0; k < 2 * L; k++) step();
    for (int i = 0; i < N; i++) g_cnt[i] = 0;
    req_valid = '1; res_ready = '0;
    for (int k = 0; k < 40; k++) begin rand_data(); step(); end
    for (int i = 0; i < N; i++) chk($sformatf("t6_credits[%0d]", i), g_cnt[i], Q);

    // Final drain.
    req_valid = '0; res_ready = '1;
    for (int k = 0; k < L + 10; k++) step();
    chk("final_busy", busy, 0);

    // Single-slot queue, one requester: one op in flight at a time.
    rst1 = 1'b0; res1_ready = '1; req1_valid = 2'b01;
    last = -1; ngr = 0;
    for (int c = 0; c < 80; c++) begin
      req1_data[0 +: IW]  = rnd_data();
      req1_data[IW +: IW] = rnd_data();
      @(negedge clk);
      chk("t4_ready1", req1_ready[1], 0);
      chk("t4_valid1", res1_valid[1], 0);
      if (res1_valid[0]) begin
        if (q1.size() == 0) chk("t4_unexpected_result", 1, 0);
        else begin
          chk("t4_data", {res1_ovf[0], res1_data[0 +: OW]}, q1[0]);
          void'(q1.pop_front());
        end
      end
      if (req1_ready[0]) begin
        if (last >= 0) chk("t4_gap", c - last, L1 + 4);
        last = c;
        ngr++;
        model_sqrt(req1_data[0 +: IW], y1, o1);
        q1.push_back({o1, y1});
      end
      @(posedge clk);
      #1;
    end
    chk("t4_grants", ngr >= 8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
